alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Byte-stream sequencer for the 8-op ALU: collects operand A, operand B and op code as three
//  consecutive bytes on a valid/ready input stream (UART RX side) and drives them to the ALU.
//  Registers the ALU result and returns it as one byte on a valid/ready output stream (UART TX side).
//  Sits between the UART RX/TX and the combinational ALU; the ALU stays a separate instance.
// PARAMETERS
//  NB_DATA      8      operand / result / stream byte width
//  NB_CODE      6      ALU op code width (taken from rx_data[NB_CODE-1:0])
//  TIMEOUT_CYC  50000  idle cycles allowed between bytes of one frame; 0 disables the timeout
//  NB_TMO       16     timeout counter width; must hold TIMEOUT_CYC
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  rx_data       in   NB_DATA  incoming byte
//  rx_valid      in   1        rx_data valid
//  rx_ready      out  1        block accepts a byte this cycle
//  alu_dato1     out  NB_DATA  registered operand A to ALU
//  alu_dato2     out  NB_DATA  registered operand B to ALU
//  alu_op_code   out  NB_CODE  registered op code to ALU
//  alu_salida    in   NB_DATA  ALU result (combinational from the three outputs above)
//  tx_data       out  NB_DATA  result byte
//  tx_valid      out  1        tx_data valid
//  tx_ready      in   1        sink accepts tx_data
//  busy          out  1        high in every state except GET_A
//  err_timeout   out  1        one-cycle pulse when a partial frame is discarded
// BEHAVIOUR
//  Reset (async assert, sync release): state GET_A. alu_dato1/alu_dato2/tx_data = 0,
//  alu_op_code = 0, tx_valid = 0, err_timeout = 0, timeout counter = 0.
//  Transfer in = rx_valid & rx_ready; transfer out = tx_valid & tx_ready.
//  FSM:
//   GET_A : rx_ready=1; on transfer: alu_dato1<=rx_data, -> GET_B
//   GET_B : rx_ready=1; on transfer: alu_dato2<=rx_data, -> GET_OP
//   GET_OP: rx_ready=1; on transfer: alu_op_code<=rx_data[NB_CODE-1:0], -> EXEC
//   EXEC  : rx_ready=0; tx_data<=alu_salida, tx_valid<=1, -> SEND (exactly one cycle)
//   SEND  : rx_ready=0; tx_valid=1, tx_data held stable until transfer out;
//           on transfer out: tx_valid<=0, -> GET_A
//  Latency: op byte accepted in cycle N -> tx_valid high from cycle N+2.
//  Back-to-back: a new A byte is accepted in the cycle after the tx transfer, not the same cycle.
//  ALU operands hold their values from capture until overwritten by the next frame.
//  Unknown op codes are not filtered: ALU returns 0, and 0x00 is sent.
//  Timeout (TIMEOUT_CYC>0): counter clears on every rx transfer and on entry to GET_A;
//   it increments each cycle in GET_B/GET_OP without a transfer. When counter==TIMEOUT_CYC-1
//   and no transfer occurs: -> GET_A, err_timeout=1 for one cycle. Captured operands remain but
//   are overwritten by the next frame. A transfer in the same cycle as expiry wins (no timeout).
//  No timeout in GET_A, EXEC or SEND; SEND waits indefinitely on tx_ready.
//  Reset mid-frame or mid-SEND: immediate return to reset values; pending result lost.
//  busy = (state != GET_A).
// STRUCTURE
//  Shared package alu_pkg: op code localparams (ADD 6'b100000, SUB 6'b100010, AND 6'b100100,
//   OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111), FSM state
//   encoding (GET_A, GET_B, GET_OP, EXEC, SEND).
//  One sub-module: frame_timeout (load-clear / enable / expire counter, NB_TMO wide).
//  The ALU is instantiated beside this block by the top level, not inside it.
// TESTING  (bench instantiates alu_seq_ctrl + ALU, TIMEOUT_CYC=20)
//  1 ADD: bytes 0x05,0x03,0x20 -> one tx byte 0x08, tx_valid at N+2 after op byte.
//  2 SUB wrap: 0x03,0x05,0x22 -> 0xFE; NOR: 0x0F,0xF0,0x27 -> 0x00; bad op 0x3F -> 0x00.
//  3 Backpressure: tx_ready low 10 cycles in SEND -> tx_valid/tx_data stable, rx_ready=0,
//    rx bytes offered meanwhile not consumed; tx_ready high -> one transfer, back to GET_A.
//  4 Timeout: send 0x11, idle 20 cycles -> err_timeout 1-cycle pulse, busy=0; then
//    0x02,0x02,0x20 -> 0x04; byte arriving on cycle 20 exactly -> no timeout.
//  5 Reset: assert rst_n=0 in GET_OP and in SEND -> all outputs to reset values at once,
//    no tx transfer; next full frame processed normally.
//  6 Streaming: 4 frames with rx_valid held high, tx_ready=1 -> 4 correct results in order,
//    no byte dropped or duplicated.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU byte-stream sequencer: ALU op codes and sequencer FSM states.
package alu_pkg;

  localparam logic [5:0] OpAdd = 6'b100000;
  localparam logic [5:0] OpSub = 6'b100010;
  localparam logic [5:0] OpAnd = 6'b100100;
  localparam logic [5:0] OpOr  = 6'b100101;
  localparam logic [5:0] OpXor = 6'b100110;
  localparam logic [5:0] OpSra = 6'b000011;
  localparam logic [5:0] OpSrl = 6'b000010;
  localparam logic [5:0] OpNor = 6'b100111;

  typedef enum logic [2:0] {
    StGetA,
    StGetB,
    StGetOp,
    StExec,
    StSend
  } seq_state_e;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte idle counter: clears on clr_i, counts while en_i, flags expiry on the last idle cycle.
module frame_timeout #(
  parameter int unsigned NbTmo      = 16,
  parameter int unsigned TimeoutCyc = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [NbTmo-1:0] Last = (TimeoutCyc == 0) ? '0 : NbTmo'(TimeoutCyc - 1);

  logic [NbTmo-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (TimeoutCyc != 0)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Clear wins over expiry so a byte arriving on the last cycle keeps the frame alive.
  assign expire_o = (TimeoutCyc != 0) && en_i && !clr_i && (cnt_q == Last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Collects A, B and op-code bytes from the RX stream, drives the external ALU and returns
// the registered result as one byte on the TX stream.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_CODE     = 6,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned NB_TMO      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NB_DATA-1:0] rx_data_i,
  input  logic               rx_valid_i,
  output logic               rx_ready_o,
  output logic [NB_DATA-1:0] alu_dato1_o,
  output logic [NB_DATA-1:0] alu_dato2_o,
  output logic [NB_CODE-1:0] alu_op_code_o,
  input  logic [NB_DATA-1:0] alu_salida_i,
  output logic [NB_DATA-1:0] tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               busy_o,
  output logic               err_timeout_o
);

  seq_state_e         state_q, state_d;
  logic [NB_DATA-1:0] dato1_q, dato1_d;
  logic [NB_DATA-1:0] dato2_q, dato2_d;
  logic [NB_CODE-1:0] op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               err_q, err_d;

  logic rx_xfer;
  logic tmo_en;
  logic tmo_expire;

  assign rx_ready_o = (state_q == StGetA) || (state_q == StGetB) || (state_q == StGetOp);
  assign rx_xfer    = rx_valid_i && rx_ready_o;
  assign tmo_en     = (state_q == StGetB) || (state_q == StGetOp);

  // Counter is held clear outside the mid-frame states, which covers the clear on GET_A entry.
  frame_timeout #(
    .NbTmo      (NB_TMO),
    .TimeoutCyc (TIMEOUT_CYC)
  ) u_frame_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (rx_xfer || !tmo_en),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d    = state_q;
    dato1_d    = dato1_q;
    dato2_d    = dato2_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    unique case (state_q)
      StGetA: begin
        if (rx_xfer) begin
          dato1_d = rx_data_i;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (rx_xfer) begin
          dato2_d = rx_data_i;
          state_d = StGetOp;
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = StGetA;
        end
      end
      StGetOp: begin
        if (rx_xfer) begin
          op_d    = rx_data_i[NB_CODE-1:0];
          state_d = StExec;
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = StGetA;
        end
      end
      StExec: begin
        tx_data_d  = alu_salida_i;
        tx_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          state_d    = StGetA;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = StGetA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StGetA;
      dato1_q    <= '0;
      dato2_q    <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dato1_q    <= dato1_d;
      dato2_q    <= dato2_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  assign alu_dato1_o   = dato1_q;
  assign alu_dato2_o   = dato2_q;
  assign alu_op_code_o = op_q;
  assign tx_data_o     = tx_data_q;
  assign tx_valid_o    = tx_valid_q;
  assign busy_o        = (state_q != StGetA);
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a behavioural ALU beside it; TIMEOUT_CYC = 20.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] alu_dato1, alu_dato2, alu_salida, tx_data;
  logic [5:0] alu_op_code;
  logic       tx_valid, tx_ready, busy, err_timeout;

  always #5 clk = ~clk;

  alu_seq_ctrl #(
    .NB_DATA     (8),
    .NB_CODE     (6),
    .TIMEOUT_CYC (20),
    .NB_TMO      (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data_i     (rx_data),
    .rx_valid_i    (rx_valid),
    .rx_ready_o    (rx_ready),
    .alu_dato1_o   (alu_dato1),
    .alu_dato2_o   (alu_dato2),
    .alu_op_code_o (alu_op_code),
    .alu_salida_i  (alu_salida),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .busy_o        (busy),
    .err_timeout_o (err_timeout)
  );

  // Reference ALU: plain arithmetic per op code, unknown codes give 0.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpXor:   return a ^ b;
      OpSra:   return sa >>> b;
      OpSrl:   return a >> b;
      OpNor:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_salida = alu_ref(alu_dato1, alu_dato2, alu_op_code);

  int         n_checks = 0;
  int         n_pass = 0;
  int         err_count = 0;
  logic [7:0] tx_log[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         rand_on;

  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) tx_log.push_back(tx_data);
    if (err_timeout) err_count++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached (got no finish, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string msg);
    n_checks++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!rx_ready) fail("rx_accept", "rx_ready got 0 required 1");
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  task automatic expect_tx(input string name, input logic [7:0] exp);
    int guard;
    guard = 0;
    while (tx_log.size() == 0 && guard < 200) begin
      tick();
      guard++;
    end
    if (tx_log.size() == 0) fail(name, "got no tx byte required one");
    else check(name, tx_log.pop_front(), exp);
  endtask

  // Offers rx_q bytes in order; with gaps, rx_valid drops on random cycles.
  task automatic stream_bytes(input bit gaps);
    int guard;
    bit v, xfer;
    guard = 0;
    while (rx_q.size() > 0 && guard < 5000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rx_valid = v;
      rx_data = rx_q[0];
      xfer = v && rx_ready;
      tick();
      if (xfer) void'(rx_q.pop_front());
      guard++;
    end
    rx_valid = 1'b0;
    if (rx_q.size() != 0) fail("stream_drain", "rx bytes left unconsumed, required none");
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[10];
  logic [5:0] ops[8];
  logic [7:0] ra, rb, rop;
  logic [7:0] stream_exp[4];
  int         bad, snap, guard;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, "add"};
    vecs[1] = '{8'h03, 8'h05, 8'h22, 8'hFE, "sub_wrap"};
    vecs[2] = '{8'h0F, 8'hF0, 8'h27, 8'h00, "nor"};
    vecs[3] = '{8'h12, 8'h34, 8'h3F, 8'h00, "bad_op"};
    vecs[4] = '{8'hF0, 8'h3C, 8'h24, 8'h30, "and"};
    vecs[5] = '{8'h0F, 8'h30, 8'h25, 8'h3F, "or"};
    vecs[6] = '{8'hFF, 8'h0F, 8'h26, 8'hF0, "xor"};
    vecs[7] = '{8'h80, 8'h02, 8'h03, 8'hE0, "sra"};
    vecs[8] = '{8'h80, 8'h02, 8'h02, 8'h20, "srl"};
    vecs[9] = '{8'h07, 8'h01, 8'hE0, 8'h08, "op_high_bits"};
    ops = '{OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSra, OpSrl, OpNor};

    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dato1", alu_dato1, 0);
    check("rst_dato2", alu_dato2, 0);
    check("rst_op", alu_op_code, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_err", err_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_ready", rx_ready, 1);
    rst_n = 1'b1;
    tick();

    // First-result latency: EXEC cycle silent, tx_valid from N+2.
    send_frame(8'h05, 8'h03, 8'h20);
    check("lat_exec_valid", tx_valid, 0);
    check("lat_exec_rx_ready", rx_ready, 0);
    tick();
    check("lat_n2_valid", tx_valid, 1);
    check("lat_n2_data", tx_data, 8'h08);
    check("lat_send_rx_ready", rx_ready, 0);
    tick();
    check("lat_back_idle", busy, 0);
    check("lat_next_a_ready", rx_ready, 1);
    check("lat_one_tx", tx_log.size(), 1);
    expect_tx("lat_tx_byte", 8'h08);

    foreach (vecs[i]) begin
      send_frame(vecs[i].a, vecs[i].b, vecs[i].op);
      expect_tx({"vec_", vecs[i].name}, vecs[i].exp);
      check({"hold_a_", vecs[i].name}, alu_dato1, vecs[i].a);
    end

    // Backpressure in SEND.
    tx_ready = 1'b0;
    send_frame(8'h10, 8'h20, 8'h20);
    tick();
    rx_valid = 1'b1;
    rx_data = 8'h55;
    bad = 0;
    repeat (10) begin
      if (!(tx_valid && tx_data == 8'h30 && !rx_ready && busy)) bad++;
      tick();
    end
    check("bp_stable", bad, 0);
    rx_valid = 1'b0;
    check("bp_no_consume", alu_dato1, 8'h10);
    check("bp_no_tx", tx_log.size(), 0);
    tx_ready = 1'b1;
    tick();
    check("bp_one_tx", tx_log.size(), 1);
    check("bp_idle", busy, 0);
    tick();
    check("bp_no_dup", tx_log.size(), 1);
    expect_tx("bp_byte", 8'h30);

    // Timeout after a lone A byte.
    snap = err_count;
    send_byte(8'h11);
    bad = 0;
    for (int i = 1; i <= 20; i++) begin
      if (err_timeout || !busy) bad++;
      tick();
    end
    check("tmo_no_early", bad, 0);
    check("tmo_pulse", err_timeout, 1);
    check("tmo_idle", busy, 0);
    tick();
    check("tmo_pulse_len", err_timeout, 0);
    check("tmo_pulse_count", err_count - snap, 1);
    send_frame(8'h02, 8'h02, 8'h20);
    expect_tx("tmo_recover", 8'h04);

    // Byte on the last allowed idle cycle keeps the frame.
    snap = err_count;
    send_byte(8'h11);
    repeat (19) tick();
    send_byte(8'h22);
    check("tmo_edge_busy", busy, 1);
    check("tmo_edge_b", alu_dato2, 8'h22);
    send_byte(8'h20);
    expect_tx("tmo_edge_result", 8'h33);
    check("tmo_edge_no_err", err_count - snap, 0);

    // Reset in GET_OP.
    send_byte(8'h44);
    send_byte(8'h55);
    rst_n = 1'b0;
    #1;
    check("rst_op_dato1", alu_dato1, 0);
    check("rst_op_dato2", alu_dato2, 0);
    check("rst_op_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in SEND: result dropped.
    tx_ready = 1'b0;
    send_frame(8'h01, 8'h01, 8'h20);
    tick();
    check("rst_send_valid_pre", tx_valid, 1);
    snap = tx_log.size();
    rst_n = 1'b0;
    #1;
    check("rst_send_valid", tx_valid, 0);
    check("rst_send_data", tx_data, 0);
    check("rst_send_op", alu_op_code, 0);
    tx_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_send_no_tx", tx_log.size(), snap);
    send_frame(8'h09, 8'h06, 8'h22);
    expect_tx("rst_send_recover", 8'h03);

    // Streaming with rx_valid held high.
    tx_log.delete();
    rx_q = '{8'h01, 8'h02, 8'h20, 8'h10, 8'h01, 8'h22, 8'hAA, 8'h55, 8'h26,
             8'hC0, 8'h01, 8'h03};
    stream_exp = '{8'h03, 8'h0F, 8'hFF, 8'hE0};
    stream_bytes(1'b0);
    for (int i = 0; i < 4; i++) expect_tx($sformatf("stream_%0d", i), stream_exp[i]);
    repeat (5) tick();
    check("stream_no_extra", tx_log.size(), 0);

    // Random frames, random gaps and backpressure, checked in order against the model.
    tx_log.delete();
    rx_q.delete();
    exp_q.delete();
    for (int f = 0; f < 30; f++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rop = 8'($urandom);
      else rop = {2'($urandom), ops[$urandom_range(0, 7)]};
      rx_q.push_back(ra);
      rx_q.push_back(rb);
      rx_q.push_back(rop);
      exp_q.push_back(alu_ref(ra, rb, rop[5:0]));
    end
    snap = err_count;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          tick();
          tx_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        stream_bytes(1'b1);
        rand_on = 1'b0;
      end
    join
    tx_ready = 1'b1;
    guard = 0;
    while (tx_log.size() < exp_q.size() && guard < 500) begin
      tick();
      guard++;
    end
    check("rand_count", tx_log.size(), exp_q.size());
    for (int i = 0; tx_log.size() > 0 && exp_q.size() > 0; i++)
      check($sformatf("rand_%0d", i), tx_log.pop_front(), exp_q.pop_front());
    check("rand_no_err", err_count - snap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
